// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds HI/LO, times multi-cycle mult/div operations
// and raises a pipeline freeze while a later mult/div-class instruction must wait.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ID_IsMD,
    output logic        busy,
    output logic        Allstall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed, neg_quot, neg_rem;
    logic [31:0] a_abs, b_abs, den, quot_mag, rem_mag, quot, rem;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    // Signed divide via magnitudes; the 0x80000000 / -1 case falls out naturally.
    assign div_signed = (op_q == OpDiv);
    assign neg_quot   = div_signed & (a_q[31] ^ b_q[31]);
    assign neg_rem    = div_signed & a_q[31];
    assign a_abs      = (div_signed & a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign b_abs      = (div_signed & b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign den        = (b_abs == 32'd0) ? 32'd1 : b_abs;
    assign quot_mag   = a_abs / den;
    assign rem_mag    = a_abs % den;
    assign quot       = neg_quot ? (~quot_mag + 32'd1) : quot_mag;
    assign rem        = neg_rem ? (~rem_mag + 32'd1) : rem_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!op_q[1]) begin
                        {hi_d, lo_d} = (op_q == OpMultu) ? prod_u : prod_s;
                    end else if (b_q != 32'd0) begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == StBusy);
    assign Allstall = ((start & ~op[2]) | busy) & ID_IsMD;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ID_IsMD;
    logic        busy;
    logic        Allstall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp  = 0;
    int n_mism = 0;

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .ID_IsMD (ID_IsMD),
        .busy    (busy),
        .Allstall(Allstall),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mism++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div op, check busy/Allstall for every cycle up to the return to idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic md, input bit inject);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1; ID_IsMD = md;
        #1 check_eq("stall_issue", 64'(Allstall), 64'(md));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (inject && k == 2) begin
                start = 1'b1; op = 3'b001; A = 32'd3; B = 32'd4;
            end else begin
                start = 1'b0; op = 3'b111; A = $urandom; B = $urandom;
            end
            #1;
            check_eq($sformatf("busy_c%0d", k), 64'(busy), 64'd1);
            check_eq($sformatf("stall_c%0d", k), 64'(Allstall), 64'(md));
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("busy_done", 64'(busy), 64'd0);
        check_eq("stall_done", 64'(Allstall), 64'd0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check_eq({tag, "_hi"}, 64'(HI), 64'(hi));
        check_eq({tag, "_lo"}, 64'(LO), 64'(lo));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0; ID_IsMD = 1'b0;
        @(negedge clk);
        ID_IsMD = 1'b1;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_stall", 64'(Allstall), 64'd0);
        check_hilo("rst", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 5, 1'b1, 1'b0);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(3'b011, 32'd100, 32'd7, 10, 1'b1, 1'b0);
        check_hilo("divu", 32'd2, 32'd14);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 1'b0);
        check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 1'b0);
        check_hilo("div_ovf", 32'h0, 32'h8000_0000);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, 1'b0);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 5, 1'b0, 1'b0);
        check_hilo("mult_nomd", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MTHI writes at the issue edge with no busy cycle
        @(negedge clk);
        op = 3'b100; A = 32'h1234_5678; start = 1'b1; ID_IsMD = 1'b1;
        #1 check_eq("mthi_stall", 64'(Allstall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("mthi_busy", 64'(busy), 64'd0);
        check_hilo("mthi", 32'h1234_5678, 32'hFFFF_FFEB);

        run_op(3'b010, 32'd55, 32'd0, 10, 1'b1, 1'b0);
        check_hilo("div_by0", 32'h1234_5678, 32'hFFFF_FFEB);
        run_op(3'b011, 32'd9, 32'd0, 10, 1'b1, 1'b0);
        check_hilo("divu_by0", 32'h1234_5678, 32'hFFFF_FFEB);

        // Reserved op is a no-op
        @(negedge clk);
        op = 3'b110; A = 32'hDEAD_BEEF; start = 1'b1;
        #1 check_eq("rsvd_stall", 64'(Allstall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("rsvd_busy", 64'(busy), 64'd0);
        check_hilo("rsvd", 32'h1234_5678, 32'hFFFF_FFEB);

        // Second start (MULTU 3*4) during busy must be ignored
        run_op(3'b011, 32'd100, 32'd7, 10, 1'b1, 1'b1);
        check_hilo("inject", 32'd2, 32'd14);

        // Reset during busy cycle 4 of a DIV
        @(negedge clk);
        op = 3'b010; A = 32'd100; B = 32'd7; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        check_hilo("async_rst", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_hilo("post_rst", 32'h0, 32'h0);
        @(negedge clk);
        op = 3'b101; A = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check_hilo("mtlo", 32'h0, 32'd5);

        // Start accepted on the first edge after reset release
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; op = 3'b100; A = 32'h0000_ABCD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check_hilo("first_edge", 32'h0000_ABCD, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
